// File: rtl/ysyx_22050078_mem_arbiter_pkg.sv
// Shared types for the NPC memory-port arbiter: FSM states and default widths.
// Latency and backpressure are not applicable; this file declares types only.
package ysyx_22050078_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int ARB_ADDR_W     = 64;
    localparam int ARB_DATA_W     = 64;
    localparam int ARB_LSU_STREAK = 4;

    // Counter width that can hold the value LSU_STREAK itself.
    function automatic int streak_w(input int max_streak);
        return (max_streak < 2) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/ysyx_22050078_mem_arbiter_if.sv
// Bundles the IFU, LSU and memory valid/ready channels of the arbiter.
// The master modport is the arbiter's view; the slave modport is the view of the requesters and the memory.
interface ysyx_22050078_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int WMASK_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_rsp_valid;
    logic [DATA_W-1:0] ifu_rsp_data;

    logic               lsu_req_valid;
    logic               lsu_req_ready;
    logic [ADDR_W-1:0]  lsu_req_addr;
    logic               lsu_req_wen;
    logic [DATA_W-1:0]  lsu_req_wdata;
    logic [WMASK_W-1:0] lsu_req_wmask;
    logic               lsu_rsp_valid;
    logic [DATA_W-1:0]  lsu_rsp_data;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_req_wen;
    logic [DATA_W-1:0]  mem_req_wdata;
    logic [WMASK_W-1:0] mem_req_wmask;
    logic               mem_rsp_valid;
    logic [DATA_W-1:0]  mem_rsp_data;

    modport master (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

endinterface

// File: rtl/ysyx_22050078_arb_pick.sv
// Winner select: LSU first unless its streak is full while IFU waits.
// Purely combinational (0 cycles); grants are zero when nobody is valid.
module ysyx_22050078_arb_pick (
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic streak_full,
    output logic gnt_ifu,
    output logic gnt_lsu
);

    assign gnt_lsu = lsu_valid & ~(ifu_valid & streak_full);
    assign gnt_ifu = ifu_valid & ~gnt_lsu;

endmodule

// File: rtl/ysyx_22050078_mem_arbiter.sv
// Shares one memory port between IFU and LSU with one transaction in flight and LSU priority bounded by a streak limit.
// Latency: grant N, mem request N+1, response N+2 at the earliest; requesters see ready=0 until the FSM returns to IDLE.
module ysyx_22050078_mem_arbiter
    import ysyx_22050078_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int LSU_STREAK = ARB_LSU_STREAK
) (
    input  logic clk,
    input  logic rst,
    ysyx_22050078_mem_arbiter_if.master bus,
    output logic o_busy,
    output logic o_gnt_lsu,
    output logic o_err
);

    localparam int WMASK_W = DATA_W / 8;
    localparam int SW      = streak_w(LSU_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LSU_STREAK);

    arb_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [WMASK_W-1:0] wmask_q, wmask_d;
    logic               gnt_lsu_q, gnt_lsu_d;
    logic [SW-1:0]      streak_q, streak_d;
    logic               err_q, err_d;
    logic               pick_ifu, pick_lsu;

    ysyx_22050078_arb_pick u_pick (
        .ifu_valid   (bus.ifu_req_valid),
        .lsu_valid   (bus.lsu_req_valid),
        .streak_full (streak_q == STREAK_MAX),
        .gnt_ifu     (pick_ifu),
        .gnt_lsu     (pick_lsu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            gnt_lsu_q <= 1'b0;
            streak_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            gnt_lsu_q <= gnt_lsu_d;
            streak_q  <= streak_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wen_d             = wen_q;
        wdata_d           = wdata_q;
        wmask_d           = wmask_q;
        gnt_lsu_d         = gnt_lsu_q;
        streak_d          = streak_q;
        err_d             = err_q;
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        bus.mem_req_valid = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                err_d             = err_q | bus.mem_rsp_valid;
                bus.ifu_req_ready = pick_ifu;
                bus.lsu_req_ready = pick_lsu;
                if (pick_lsu) begin
                    state_d   = ARB_REQ;
                    addr_d    = bus.lsu_req_addr;
                    wen_d     = bus.lsu_req_wen;
                    wdata_d   = bus.lsu_req_wdata;
                    wmask_d   = bus.lsu_req_wmask;
                    gnt_lsu_d = 1'b1;
                    // Streak only grows while IFU is actually being held off.
                    if (!bus.ifu_req_valid)         streak_d = '0;
                    else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
                end else if (pick_ifu) begin
                    state_d   = ARB_REQ;
                    addr_d    = bus.ifu_req_addr;
                    wen_d     = 1'b0;
                    wdata_d   = '0;
                    wmask_d   = '0;
                    gnt_lsu_d = 1'b0;
                    streak_d  = '0;
                end
            end
            ARB_REQ: begin
                bus.mem_req_valid = 1'b1;
                err_d             = err_q | bus.mem_rsp_valid;
                if (bus.mem_req_ready) state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (bus.mem_rsp_valid) begin
                    bus.lsu_rsp_valid = gnt_lsu_q;
                    bus.ifu_rsp_valid = ~gnt_lsu_q;
                    state_d           = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.ifu_rsp_data  = bus.mem_rsp_data;
    assign bus.lsu_rsp_data  = bus.mem_rsp_data;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;

    assign o_busy    = (state_q != ARB_IDLE);
    assign o_gnt_lsu = gnt_lsu_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_ysyx_22050078_mem_arbiter.sv
// Directed bench for the memory arbiter: single reads/stores, streak fairness, memory stall, spurious responses, async reset.
// Inputs change 1ns after the rising edge; outputs are sampled in the same quiet window.
module tb_ysyx_22050078_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_busy, o_gnt_lsu, o_err;
    int   checks = 0;
    int   errors = 0;

    ysyx_22050078_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ysyx_22050078_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LSU_STREAK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_busy    (o_busy),
        .o_gnt_lsu (o_gnt_lsu),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_addr  = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = '0;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_wdata = '0;
        bus.lsu_req_wmask = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    logic [5:0] exp_lsu_order;

    initial begin
        idle_inputs();
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_gnt", o_gnt_lsu, 0);
        chk("rst_err", o_err, 0);
        chk("rst_memv", bus.mem_req_valid, 0);
        chk("rst_rdy", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        rst = 1'b0;
        tick();

        // 1: IFU-only read
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h8000_0000;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("t1_ifu_rdy", bus.ifu_req_ready, 1);
        chk("t1_lsu_rdy", bus.lsu_req_ready, 0);
        tick();
        bus.ifu_req_valid = 1'b0;
        chk("t1_memv", bus.mem_req_valid, 1);
        chk("t1_addr", bus.mem_req_addr, 64'h8000_0000);
        chk("t1_wen_wmask", {bus.mem_req_wen, bus.mem_req_wmask}, 0);
        chk("t1_gnt", o_gnt_lsu, 0);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h0010_0073;
        #1;
        chk("t1_rspv", bus.ifu_rsp_valid, 1);
        chk("t1_rspd", bus.ifu_rsp_data, 64'h0010_0073);
        chk("t1_lsu_rspv", bus.lsu_rsp_valid, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("t1_idle", o_busy, 0);

        // 2: LSU store
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h8000_1000;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_wdata = 64'hDEAD_BEEF;
        bus.lsu_req_wmask = 8'h0F;
        #1;
        chk("t2_lsu_rdy", bus.lsu_req_ready, 1);
        chk("t2_ifu_rdy", bus.ifu_req_ready, 0);
        tick();
        idle_inputs();
        bus.mem_req_ready = 1'b1;
        chk("t2_memv", bus.mem_req_valid, 1);
        chk("t2_addr", bus.mem_req_addr, 64'h8000_1000);
        chk("t2_wen", bus.mem_req_wen, 1);
        chk("t2_wdata", bus.mem_req_wdata, 64'hDEAD_BEEF);
        chk("t2_wmask", bus.mem_req_wmask, 8'h0F);
        chk("t2_gnt", o_gnt_lsu, 1);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h1234;
        #1;
        chk("t2_rspv", bus.lsu_rsp_valid, 1);
        chk("t2_rspd", bus.lsu_rsp_data, 64'h1234);
        chk("t2_ifu_rspv", bus.ifu_rsp_valid, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        #1;
        chk("t2_pulse_once", bus.lsu_rsp_valid, 0);

        // 3: both valid continuously, 5th grant goes to IFU
        exp_lsu_order = 6'b101111;  // bit i = grant i is LSU
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h8000_0100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h8000_2000;
        bus.mem_req_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk($sformatf("t3_lsu_rdy%0d", g), bus.lsu_req_ready, exp_lsu_order[g]);
            chk($sformatf("t3_ifu_rdy%0d", g), bus.ifu_req_ready, !exp_lsu_order[g]);
            tick();
            chk($sformatf("t3_addr%0d", g), bus.mem_req_addr,
                exp_lsu_order[g] ? 64'h8000_2000 : 64'h8000_0100);
            tick();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 64'(g);
            tick();
            bus.mem_rsp_valid = 1'b0;
        end
        idle_inputs();

        // 4: memory stalls in REQ for 5 cycles
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h8000_3008;
        #1;
        chk("t4_lsu_rdy", bus.lsu_req_ready, 1);
        tick();
        idle_inputs();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h8000_0200;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t4_memv%0d", c), bus.mem_req_valid, 1);
            chk($sformatf("t4_addr%0d", c), bus.mem_req_addr, 64'h8000_3008);
            chk($sformatf("t4_rdy%0d", c), {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            chk($sformatf("t4_busy%0d", c), o_busy, 1);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        chk("t4_resp_rdy", bus.ifu_req_ready, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hCAFE_F00D_0000_0001;
        #1;
        chk("t4_rspv", bus.lsu_rsp_valid, 1);
        chk("t4_rspd", bus.lsu_rsp_data, 64'hCAFE_F00D_0000_0001);
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("t4_idle", o_busy, 0);
        chk("t4_err_clean", o_err, 0);

        // 5: spurious response in IDLE
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h5555;
        #1;
        chk("t5_no_pulse", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("t5_err", o_err, 1);
        chk("t5_still_idle", o_busy, 0);
        tick();
        tick();
        chk("t5_err_sticky", o_err, 1);

        // 6: async reset while in RESP
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("t6_err_cleared", o_err, 0);
        tick();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h8000_0400;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        tick();
        chk("t6_in_resp", o_busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_busy", o_busy, 0);
        chk("t6_memv", bus.mem_req_valid, 0);
        chk("t6_gnt", o_gnt_lsu, 0);
        chk("t6_addr", bus.mem_req_addr, 0);
        tick();
        rst = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h7777;
        #1;
        chk("t6_no_pulse", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("t6_err", o_err, 1);
        chk("t6_idle", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
